// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared constants and types for the RV32I core.
// Revision: 1.0
`default_nettype none

package rv_core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    TRAP  = 2'd2
  } pc_state_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and fetch sequencer (FETCH -> ISSUE -> FETCH, sticky TRAP).
// Optional macro PC_FETCH_COUNT_EN adds fetch_count_o. Revision: 1.0
`default_nettype none

module pc_fetch_unit #(
  parameter logic [rv_core_pkg::XLEN-1:0] RESET_VECTOR = rv_core_pkg::DEFAULT_RESET_VECTOR,
  parameter logic [rv_core_pkg::XLEN-1:0] NOP_INSTR    = rv_core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        trap_o,
  output logic [31:0] trap_addr_o
`ifdef PC_FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count_o
`endif
);

  import rv_core_pkg::*;

  pc_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_trap;
  logic [31:0] r_trap_addr;

  pc_state_t   w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic        w_valid_nxt;
  logic        w_trap_nxt;
  logic [31:0] w_trap_addr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_VECTOR;
      r_instr     <= NOP_INSTR;
      r_valid     <= 1'b0;
      r_trap      <= 1'b0;
      r_trap_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_valid     <= w_valid_nxt;
      r_trap      <= w_trap_nxt;
      r_trap_addr <= w_trap_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_instr_nxt     = r_instr;
    w_valid_nxt     = r_valid;
    w_trap_nxt      = r_trap;
    w_trap_addr_nxt = r_trap_addr;
    case (r_state)
      FETCH: begin
        if (imem_ready_i) begin
          w_instr_nxt = imem_rdata_i;
          w_valid_nxt = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Stall wins over redirect; the redirect is held upstream until it clears.
        if (!stall_i) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
          if (!redirect_i) begin
            w_pc_nxt    = pc_plus4_i;
            w_state_nxt = FETCH;
          end else if (is_word_aligned(redirect_target_i)) begin
            w_pc_nxt    = redirect_target_i;
            w_state_nxt = FETCH;
          end else begin
            w_trap_nxt      = 1'b1;
            w_trap_addr_nxt = redirect_target_i;
            w_state_nxt     = TRAP;
          end
        end
      end
      TRAP: begin
        w_state_nxt = TRAP;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  assign pc_o          = r_pc;
  assign imem_addr_o   = r_pc;
  assign imem_req_o    = (r_state == FETCH) && !rst;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_valid;
  assign trap_o        = r_trap;
  assign trap_addr_o   = r_trap_addr;

`ifdef PC_FETCH_COUNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if ((r_state == FETCH) && imem_ready_i) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count_o = r_fetch_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus with a behavioural reference model of pc_fetch_unit.
`default_nettype none

module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] target = 32'h0;

  logic [31:0] pc, pc_plus4, addr, rdata, instr, trap_addr;
  logic        req, valid, trap;

  logic [31:0] w_pc, w_pc_plus4, w_addr, w_instr, w_trap_addr;
  logic        w_req, w_valid, w_trap;

`ifdef PC_FETCH_COUNT_EN
  logic [31:0] fcount, w_fcount;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  bit compare_on = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00A0_0093;
      32'h4:   return 32'h0010_8113;
      default: return a ^ 32'h5A5A_0013;
    endcase
  endfunction

  // External PC+4 adders.
  assign pc_plus4   = pc + 32'd4;
  assign w_pc_plus4 = w_pc + 32'd4;
  assign rdata      = memword(addr);

  pc_fetch_unit u_dut (
    .clk(clk), .rst(rst), .pc_o(pc), .pc_plus4_i(pc_plus4),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ready_i(ready), .imem_rdata_i(rdata),
    .instr_o(instr), .instr_valid_o(valid), .stall_i(stall), .redirect_i(redir),
    .redirect_target_i(target), .trap_o(trap), .trap_addr_o(trap_addr)
`ifdef PC_FETCH_COUNT_EN
    , .fetch_count_o(fcount)
`endif
  );

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .pc_o(w_pc), .pc_plus4_i(w_pc_plus4),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ready_i(1'b1), .imem_rdata_i(NOP),
    .instr_o(w_instr), .instr_valid_o(w_valid), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_target_i(32'h0), .trap_o(w_trap), .trap_addr_o(w_trap_addr)
`ifdef PC_FETCH_COUNT_EN
    , .fetch_count_o(w_fcount)
`endif
  );

  // Reference model: 0 = waiting for memory, 1 = holding an instruction, 2 = trapped.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_taddr, m_cnt;
  logic        m_valid, m_trap;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_trap = 1'b0; m_taddr = 32'h0; m_cnt = 32'h0;
    end else if (m_mode == 0) begin
      if (ready) begin
        m_instr = memword(m_pc); m_valid = 1'b1; m_mode = 1; m_cnt = m_cnt + 1;
      end
    end else if (m_mode == 1 && !stall) begin
      m_valid = 1'b0; m_instr = NOP;
      if (!redir) begin
        m_pc = m_pc + 4; m_mode = 0;
      end else if (target % 4 == 0) begin
        m_pc = target; m_mode = 0;
      end else begin
        m_trap = 1'b1; m_taddr = target; m_mode = 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (compare_on) begin
      chk("model_pc", pc, m_pc);
      chk("model_addr", addr, m_pc);
      chk("model_req", {31'b0, req}, {31'b0, !rst && m_mode == 0});
      chk("model_instr", instr, m_instr);
      chk("model_valid", {31'b0, valid}, {31'b0, m_valid});
      chk("model_trap", {31'b0, trap}, {31'b0, m_trap});
      chk("model_trap_addr", trap_addr, m_taddr);
`ifdef PC_FETCH_COUNT_EN
      chk("model_count", fcount, m_cnt);
`endif
    end
  end

  task automatic step(input logic r, input logic rd, input logic st, input logic rdr,
                      input logic [31:0] tgt);
    rst = r; ready = rd; stall = st; redir = rdr; target = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    step(1, 1, 0, 0, 0);
    compare_on = 1'b1;
    step(1, 1, 0, 0, 0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'b0, valid}, 32'h0);
    chk("reset_instr", instr, NOP);
    chk("reset_trap", {31'b0, trap}, 32'h0);
    chk("reset_req_forced", {31'b0, req}, 32'h0);
    chk("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);

    // Sequential fetch with zero-wait memory.
    step(0, 1, 0, 0, 0);
    chk("fetch0_instr", instr, 32'h00A0_0093);
    chk("fetch0_valid", {31'b0, valid}, 32'h1);
    step(0, 1, 0, 0, 0);
    chk("seq_pc4", pc, 32'h4);
    chk("wrap_pc", w_pc, 32'h0);
    chk("wrap_no_trap", {31'b0, w_trap}, 32'h0);

    // Three wait states at pc 0x4.
    repeat (3) step(0, 0, 0, 0, 0);
    chk("wait_addr", addr, 32'h4);
    chk("wait_valid", {31'b0, valid}, 32'h0);
    step(0, 1, 0, 0, 0);
    chk("fetch4_instr", instr, 32'h0010_8113);
    step(0, 1, 0, 0, 0);
    chk("seq_pc8", pc, 32'h8);
    step(0, 1, 0, 0, 0);

    // Stall with a pending redirect, then release.
    repeat (2) step(0, 1, 1, 1, 32'h100);
    chk("stall_pc", pc, 32'h8);
    chk("stall_valid", {31'b0, valid}, 32'h1);
    step(0, 1, 0, 1, 32'h100);
    chk("redir_pc", pc, 32'h100);
    chk("redir_addr", addr, 32'h100);
    step(0, 1, 0, 0, 0);

    // Misaligned redirect traps.
    step(0, 1, 0, 1, 32'h102);
    chk("trap_flag", {31'b0, trap}, 32'h1);
    chk("trap_addr", trap_addr, 32'h102);
    chk("trap_pc", pc, 32'h100);
    repeat (3) step(0, 1, 0, 0, 0);
    chk("trap_no_req", {31'b0, req}, 32'h0);

    // Reset clears the trap; late ready under reset is ignored.
    step(1, 1, 0, 0, 0);
    chk("rst_trap_clear", {31'b0, trap}, 32'h0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("late_ready_valid", {31'b0, valid}, 32'h0);
    chk("late_ready_pc", pc, 32'h0);

    // Five accepted fetches.
    repeat (4) begin
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
    end
    step(0, 1, 0, 0, 0);
    chk("fifth_fetch_pc", pc, 32'h10);
`ifdef PC_FETCH_COUNT_EN
    chk("count_five", fcount, 32'd5);
    step(1, 1, 0, 0, 0);
    chk("count_reset", fcount, 32'd0);
`endif
    step(0, 1, 0, 0, 0);
    compare_on = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
